meu_nibble_serial_adder: RTL and testbench



---
 rtl/meu_nibble_serial_adder.sv | 162 ++++++++++++++++
 tb/tb_meu_nibble_serial_adder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/meu_nibble_serial_adder.sv
// +--------------------------------------------------------------------------+
// | meu_nibble_serial_adder : nibble-serial wide adder over meu_fourbits_adder |
// | Optional macro MEU_SERIAL_OVF_EN adds signed-overflow output overflow_o.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module meu_fourbits_adder (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       carry_i,
    output logic [3:0] sum_o,
    output logic       carry_o
);
    assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, carry_i};
endmodule

module meu_nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   op_valid_i,
    output logic                   op_ready_o,
    input  logic [4*NIBBLES-1:0]   a_i,
    input  logic [4*NIBBLES-1:0]   b_i,
    input  logic                   carry_i,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [4*NIBBLES-1:0]   sum_o,
`ifdef MEU_SERIAL_OVF_EN
    output logic                   overflow_o,
`endif
    output logic                   carry_o
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_acc;
    logic [W-1:0]    r_sum;
    logic            r_carry;
    logic            r_cout;
    logic [W-1:0]    w_acc_next;
    logic [3:0]      w_nib_sum;
    logic            w_nib_cout;
    logic            w_last;

    meu_fourbits_adder u_add (
        .a_i     (r_a[3:0]),
        .b_i     (r_b[3:0]),
        .carry_i (r_carry),
        .sum_o   (w_nib_sum),
        .carry_o (w_nib_cout)
    );

    assign w_last = (r_cnt == C_LAST);

    // Accumulator with the current nibble merged in, so the final edge can
    // publish the complete sum without exposing partial results on sum_o.
    always_comb begin
        w_acc_next = r_acc;
        for (int n = 0; n < NIBBLES; n++) begin
            if (r_cnt == CW'(n)) begin
                w_acc_next[4*n +: 4] = w_nib_sum;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (op_valid_i) w_state_next = RUN;
            RUN:     if (w_last)     w_state_next = DONE;
            DONE:    if (res_ready_i) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (op_valid_i) begin
                        r_a     <= a_i;
                        r_b     <= b_i;
                        r_carry <= carry_i;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                    end
                end
                RUN: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_nib_cout;
                    r_a     <= r_a >> 4;
                    r_b     <= r_b >> 4;
                    if (w_last) begin
                        r_cnt  <= '0;
                        r_sum  <= w_acc_next;
                        r_cout <= w_nib_cout;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEU_SERIAL_OVF_EN
    logic r_ovf;
    logic w_cin_msb;

    // Carry into bit 3 of the top nibble recovered from its operand and sum bits.
    assign w_cin_msb = r_a[3] ^ r_b[3] ^ w_nib_sum[3];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_ovf <= 1'b0;
        end else if (r_state == RUN && w_last) begin
            r_ovf <= w_cin_msb ^ w_nib_cout;
        end
    end

    assign overflow_o = r_ovf;
`endif

    assign op_ready_o  = (r_state == IDLE);
    assign res_valid_o = (r_state == DONE);
    assign sum_o       = r_sum;
    assign carry_o     = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_meu_nibble_serial_adder.sv
// +--------------------------------------------------------------------------+
// | tb_meu_nibble_serial_adder : directed self-checking bench, NIBBLES = 4     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_meu_nibble_serial_adder;
    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk;
    logic         rst_n;
    logic         op_valid;
    logic         op_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef MEU_SERIAL_OVF_EN
    logic         ovf;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    meu_nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .op_valid_i  (op_valid),
        .op_ready_o  (op_ready),
        .a_i         (a),
        .b_i         (b),
        .carry_i     (cin),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .sum_o       (sum),
`ifdef MEU_SERIAL_OVF_EN
        .overflow_o  (ovf),
`endif
        .carry_o     (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand pair and check latency, sum and carry.
    task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic [W-1:0] exp_sum, input logic exp_cout);
        total_cnt++;
        if (op_ready !== 1'b1) $display("FAIL %s ready: got %b want 1", name, op_ready);
        else pass_cnt++;
        a = ta; b = tb; cin = tc; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        a = '1; b = '1; cin = 1'b1;
        for (int i = 1; i <= NIBBLES; i++) begin
            step();
            if (i < NIBBLES && res_valid !== 1'b0) begin
                total_cnt++;
                $display("FAIL %s early_valid cycle %0d: got %b want 0", name, i, res_valid);
            end
        end
        total_cnt++;
        if (res_valid !== 1'b1) $display("FAIL %s latency: valid got %b want 1", name, res_valid);
        else pass_cnt++;
        total_cnt++;
        if (sum !== exp_sum) $display("FAIL %s sum: got %h want %h", name, sum, exp_sum);
        else pass_cnt++;
        total_cnt++;
        if (cout !== exp_cout) $display("FAIL %s carry: got %b want %b", name, cout, exp_cout);
        else pass_cnt++;
    endtask

    task automatic drain(input string name);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        total_cnt++;
        if (op_ready !== 1'b1 || res_valid !== 1'b0)
            $display("FAIL %s drain: ready/valid got %b%b want 10", name, op_ready, res_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; op_valid = 1'b0; res_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        total_cnt++;
        if (res_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || op_ready !== 1'b1)
            $display("FAIL reset: valid=%b sum=%h carry=%b ready=%b want 0 0000 0 1",
                     res_valid, sum, cout, op_ready);
        else pass_cnt++;
`ifdef MEU_SERIAL_OVF_EN
        total_cnt++;
        if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf);
        else pass_cnt++;
`endif
    endtask

    task automatic test_basic();
        run_op("basic", 16'h0001, 16'h0000, 1'b0, 16'h0001, 1'b0);
        drain("basic");
    endtask

    task automatic test_carry_chain();
        run_op("chain1", 16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0);
        drain("chain1");
        run_op("chain2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        drain("chain2");
        run_op("fullscale", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
        drain("fullscale");
        run_op("mixed", 16'h1234, 16'h5678, 1'b1, 16'h68AD, 1'b0);
        drain("mixed");
    endtask

    task automatic test_backpressure();
        run_op("bp", 16'h8421, 16'h1248, 1'b0, 16'h9669, 1'b0);
        a = 16'h0003; b = 16'h0004; cin = 1'b0; op_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            total_cnt++;
            if (sum !== 16'h9669 || cout !== 1'b0 || res_valid !== 1'b1 || op_ready !== 1'b0)
                $display("FAIL bp_hold cycle %0d: sum=%h carry=%b valid=%b ready=%b want 9669 0 1 0",
                         i, sum, cout, res_valid, op_ready);
            else pass_cnt++;
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        total_cnt++;
        if (op_ready !== 1'b1 || res_valid !== 1'b0)
            $display("FAIL bp_release: ready/valid got %b%b want 10", op_ready, res_valid);
        else pass_cnt++;
        step();
        op_valid = 1'b0;
        total_cnt++;
        if (op_ready !== 1'b0) $display("FAIL bp_accept: ready got %b want 0", op_ready);
        else pass_cnt++;
        for (int i = 1; i <= NIBBLES; i++) step();
        total_cnt++;
        if (res_valid !== 1'b1 || sum !== 16'h0007 || cout !== 1'b0)
            $display("FAIL bp_next: valid=%b sum=%h carry=%b want 1 0007 0", res_valid, sum, cout);
        else pass_cnt++;
        drain("bp_next");
    endtask

    task automatic test_reset_mid_run();
        a = 16'h1234; b = 16'h1111; cin = 1'b0; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        total_cnt++;
        if (op_ready !== 1'b1 || res_valid !== 1'b0 || sum !== '0)
            $display("FAIL midrst_state: ready=%b valid=%b sum=%h want 1 0 0000", op_ready, res_valid, sum);
        else pass_cnt++;
        for (int i = 0; i < NIBBLES + 2; i++) begin
            step();
            if (res_valid !== 1'b0) begin
                total_cnt++;
                $display("FAIL midrst_valid cycle %0d: got %b want 0", i, res_valid);
            end
        end
        run_op("after_rst", 16'h0007, 16'h0001, 1'b0, 16'h0008, 1'b0);
        drain("after_rst");
    endtask

`ifdef MEU_SERIAL_OVF_EN
    task automatic test_overflow();
        run_op("ovf1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
        total_cnt++;
        if (ovf !== 1'b1) $display("FAIL ovf1: got %b want 1", ovf);
        else pass_cnt++;
        drain("ovf1");
        total_cnt++;
        if (ovf !== 1'b1) $display("FAIL ovf1_hold: got %b want 1", ovf);
        else pass_cnt++;
        run_op("ovf0", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        total_cnt++;
        if (ovf !== 1'b0) $display("FAIL ovf0: got %b want 0", ovf);
        else pass_cnt++;
        drain("ovf0");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_carry_chain();
        test_backpressure();
        test_reset_mid_run();
`ifdef MEU_SERIAL_OVF_EN
        test_overflow();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
